// File: rtl/sc1_rom_arbiter.sv
// Round-robin arbiter sharing one pipelined program ROM between several sc1 cores.
// Grant one cycle after request; data returns ROM_LATENCY+2 edges after request, one-hot rvalid.
module sc1_rom_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int ROM_LATENCY = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            rvalid,
    output logic [DATA_WIDTH-1:0]         rdata,
    output logic [ADDR_WIDTH-1:0]         rom_addr,
    input  logic [DATA_WIDTH-1:0]         rom_data,
    output logic                          idle
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    typedef logic [IDX_W-1:0] idx_t;

    function automatic logic [NUM_REQ-1:0] onehot(input idx_t i);
        onehot    = '0;
        onehot[i] = 1'b1;
    endfunction

    logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];
    logic [NUM_REQ-1:0]    busy;
    logic [NUM_REQ-1:0]    busy_nxt;
    logic [NUM_REQ-1:0]    eligible;
    logic [NUM_REQ-1:0]    gnt_nxt;
    idx_t                  last_grant;
    idx_t                  win;
    logic                  win_vld;
    int                    cand;

    // In-flight reads: stage s is visible in the cycle s+1 after the grant edge.
    logic                  pipe_vld [ROM_LATENCY+1];
    idx_t                  pipe_idx [ROM_LATENCY+1];

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            addr_arr[i] = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        end
    end

    assign eligible = req & ~busy;

    // Search starts just after the previous winner so every requester gets a turn.
    always_comb begin
        win_vld = 1'b0;
        win     = last_grant;
        cand    = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(last_grant) + k) % NUM_REQ;
            if (!win_vld && eligible[idx_t'(cand)]) begin
                win_vld = 1'b1;
                win     = idx_t'(cand);
            end
        end
    end

    always_comb begin
        gnt_nxt  = win_vld ? onehot(win) : '0;
        busy_nxt = (busy & ~rvalid) | gnt_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt        <= '0;
            busy       <= '0;
            idle       <= 1'b1;
            rom_addr   <= '0;
            last_grant <= idx_t'(NUM_REQ - 1);
        end else begin
            gnt  <= gnt_nxt;
            busy <= busy_nxt;
            idle <= ~|busy_nxt;
            if (win_vld) begin
                rom_addr   <= addr_arr[win];
                last_grant <= win;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s <= ROM_LATENCY; s++) begin
                pipe_vld[s] <= 1'b0;
                pipe_idx[s] <= '0;
            end
            rvalid <= '0;
            rdata  <= '0;
        end else begin
            pipe_vld[0] <= win_vld;
            pipe_idx[0] <= win;
            for (int s = 1; s <= ROM_LATENCY; s++) begin
                pipe_vld[s] <= pipe_vld[s-1];
                pipe_idx[s] <= pipe_idx[s-1];
            end
            rvalid <= pipe_vld[ROM_LATENCY] ? onehot(pipe_idx[ROM_LATENCY]) : '0;
            if (pipe_vld[ROM_LATENCY]) begin
                rdata <= rom_data;
            end
        end
    end

    gnt_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(gnt));
    rvalid_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(rvalid));

endmodule

// File: tb/tb_sc1_rom_arbiter.sv
// Directed bench for sc1_rom_arbiter: a latency-1 instance and a latency-3 instance.
module tb_sc1_rom_arbiter;
    localparam int NR = 4;
    localparam int AW = 8;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [NR-1:0]    req, gnt, rvalid;
    logic [NR*AW-1:0] req_addr;
    logic [DW-1:0]    rdata, rom_data;
    logic [AW-1:0]    rom_addr;
    logic             idle;

    logic [NR-1:0]    req_l3, gnt_l3, rvalid_l3;
    logic [NR*AW-1:0] req_addr_l3;
    logic [DW-1:0]    rdata_l3, rom_data_l3;
    logic [AW-1:0]    rom_addr_l3;
    logic             idle_l3;

    sc1_rom_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROM_LATENCY(1)) dut (
        .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .gnt(gnt),
        .rvalid(rvalid), .rdata(rdata), .rom_addr(rom_addr), .rom_data(rom_data), .idle(idle));

    sc1_rom_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROM_LATENCY(3)) dut_l3 (
        .clk(clk), .reset(reset), .req(req_l3), .req_addr(req_addr_l3), .gnt(gnt_l3),
        .rvalid(rvalid_l3), .rdata(rdata_l3), .rom_addr(rom_addr_l3), .rom_data(rom_data_l3),
        .idle(idle_l3));

    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
        return {16'hDEAD, 8'h00, a};
    endfunction

    // ROM models: word valid L cycles after the address cycle.
    logic [DW-1:0] r3_a, r3_b;
    always @(posedge clk) begin
        rom_data    <= rom_word(rom_addr);
        r3_a        <= rom_word(rom_addr_l3);
        r3_b        <= r3_a;
        rom_data_l3 <= r3_b;
    end

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int i, input logic [AW-1:0] a);
        req_addr[i*AW +: AW] = a;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        req         = '0;
        req_l3      = '0;
        req_addr    = '0;
        req_addr_l3 = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [NR-1:0]  seen;
        logic [AW-1:0]  cur_addr [NR];
        int             cnt [NR];
        int             total, n_gnt, cyc, exp_g, idx;
        logic [NR-1:0]  exp_oh;

        do_reset();
        reset = 1'b1;
        #1;
        chk("rst_gnt", gnt, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_idle", idle, 1);
        reset = 1'b0;

        // single requester, latency 1
        req[2] = 1'b1;
        set_addr(2, 8'h10);
        step();
        chk("s1_gnt_c1", gnt, 4'b0100);
        chk("s1_addr_c1", rom_addr, 8'h10);
        chk("s1_idle_c1", idle, 0);
        step();
        chk("s1_gnt_c2", gnt, 0);
        chk("s1_rvalid_c2", rvalid, 0);
        step();
        chk("s1_rvalid_c3", rvalid, 4'b0100);
        chk("s1_rdata_c3", rdata, 32'hDEAD0010);
        chk("s1_gnt_c3", gnt, 0);
        req = '0;
        step();
        chk("s1_rvalid_c4", rvalid, 0);
        chk("s1_gnt_c4", gnt, 0);
        chk("s1_idle_c4", idle, 1);

        // two simultaneous requesters
        do_reset();
        req = 4'b0011;
        set_addr(0, 8'h21);
        set_addr(1, 8'h42);
        step();
        chk("s2_gnt_c1", gnt, 4'b0001);
        chk("s2_addr_c1", rom_addr, 8'h21);
        step();
        chk("s2_gnt_c2", gnt, 4'b0010);
        chk("s2_addr_c2", rom_addr, 8'h42);
        step();
        chk("s2_rvalid_c3", rvalid, 4'b0001);
        chk("s2_rdata_c3", rdata, 32'hDEAD0021);
        chk("s2_gnt_c3", gnt, 0);
        req[0] = 1'b0;
        step();
        chk("s2_rvalid_c4", rvalid, 4'b0010);
        chk("s2_rdata_c4", rdata, 32'hDEAD0042);
        chk("s2_gnt_c4", gnt, 0);
        req[1] = 1'b0;
        step();
        chk("s2_rvalid_c5", rvalid, 0);
        chk("s2_idle_c5", idle, 1);

        // reset with two reads in flight (no reset beforehand, so rdata/rom_addr are non-zero)
        req = 4'b0011;
        step();
        step();
        chk("s5_gnt_c2", gnt, 4'b0010);
        reset = 1'b1;
        #1;
        chk("s5_rst_gnt", gnt, 0);
        chk("s5_rst_rvalid", rvalid, 0);
        chk("s5_rst_rdata", rdata, 0);
        chk("s5_rst_rom_addr", rom_addr, 0);
        chk("s5_rst_idle", idle, 1);
        req = '0;
        step();
        reset = 1'b0;
        seen = '0;
        for (int c = 0; c < 6; c++) begin
            step();
            seen = seen | rvalid | gnt;
        end
        chk("s5_no_rvalid_after_rst", seen, 0);
        req[3] = 1'b1;
        set_addr(3, 8'h33);
        step();
        chk("s5_gnt_c1", gnt, 4'b1000);
        chk("s5_addr_c1", rom_addr, 8'h33);
        step();
        chk("s5_rvalid_c2", rvalid, 0);
        step();
        chk("s5_rvalid_c3", rvalid, 4'b1000);
        chk("s5_rdata_c3", rdata, 32'hDEAD0033);
        req = '0;
        step();

        // withdrawn request
        do_reset();
        req = 4'b0011;
        set_addr(0, 8'h05);
        set_addr(1, 8'h06);
        step();
        chk("s6_gnt_c1", gnt, 4'b0001);
        req[1] = 1'b0;
        step();
        chk("s6_gnt_c2", gnt, 0);
        step();
        chk("s6_rvalid_c3", rvalid, 4'b0001);
        chk("s6_rdata_c3", rdata, 32'hDEAD0005);
        req[0] = 1'b0;
        seen = '0;
        for (int c = 0; c < 5; c++) begin
            step();
            seen = seen | {3'b000, gnt[1]} | {3'b000, rvalid[1]};
        end
        chk("s6_no_req1_activity", seen, 0);

        // all four requesters streaming 64 reads each
        do_reset();
        for (int i = 0; i < NR; i++) begin
            cnt[i]      = 0;
            cur_addr[i] = AW'(i * 8'h40);
            set_addr(i, cur_addr[i]);
        end
        req   = 4'b1111;
        total = 0;
        n_gnt = 0;
        cyc   = 0;
        exp_g = 0;
        while (total < 256 && cyc < 2000) begin
            step();
            cyc++;
            if (gnt != 0) begin
                exp_oh = 4'b0001 << exp_g;
                chk("s3_gnt_order", gnt, exp_oh);
                exp_g = (exp_g + 1) % NR;
                n_gnt++;
            end
            if (rvalid != 0) begin
                idx = 0;
                for (int i = 0; i < NR; i++) if (rvalid[i]) idx = i;
                chk("s3_rvalid_onehot", $countones(rvalid), 1);
                chk("s3_rdata", rdata, rom_word(cur_addr[idx]));
                cnt[idx]++;
                total++;
                if (cnt[idx] == 64) begin
                    req[idx] = 1'b0;
                end else begin
                    cur_addr[idx] = AW'(idx * 8'h40 + cnt[idx]);
                    set_addr(idx, cur_addr[idx]);
                end
            end
        end
        chk("s3_total_rvalid", total, 256);
        chk("s3_total_gnt", n_gnt, 256);
        chk("s3_cycles", cyc, 258);
        for (int i = 0; i < NR; i++) chk("s3_per_req_count", cnt[i], 64);
        req = '0;
        step();
        step();
        chk("s3_idle_end", idle, 1);

        // latency-3 instance, single requester held high
        do_reset();
        req_l3[2] = 1'b1;
        req_addr_l3[2*AW +: AW] = 8'h10;
        step();
        chk("s4_gnt_c1", gnt_l3, 4'b0100);
        chk("s4_addr_c1", rom_addr_l3, 8'h10);
        seen = '0;
        for (int c = 2; c <= 4; c++) begin
            step();
            seen = seen | rvalid_l3 | gnt_l3;
        end
        chk("s4_quiet_c2_c4", seen, 0);
        step();
        chk("s4_rvalid_c5", rvalid_l3, 4'b0100);
        chk("s4_rdata_c5", rdata_l3, 32'hDEAD0010);
        chk("s4_idle_c5", idle_l3, 0);
        step();
        chk("s4_gnt_c6", gnt_l3, 0);
        step();
        chk("s4_regnt_c7", gnt_l3, 4'b0100);
        req_l3 = '0;
        for (int c = 0; c < 6; c++) step();
        chk("s4_idle_end", idle_l3, 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
